cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss handler for the 2-way set-associative cache.
- On a miss it streams one 16-byte block from main memory and writes each returned word into the data array.
- It then writes {valid, tag} into the selected set of the tag/metadata array. The metadata array picks the way from its own LRU bit.
- Sits between the cache hit logic and the memory port. One instance each for the I-cache and D-cache.

Parameters:
- ADDR_W, 16, byte address width. Address split is tag[15:10], index[9:4], offset[3:0].
- WORDS, 8, 16-bit words per block.
- MEM_LAT, 4, memory read latency in cycles (informational; the FSM relies only on memory_data_valid).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- miss_detected  in  1  cache miss this cycle; sampled only in IDLE
- miss_address  in  16  byte address of the missing access
- memory_data_valid  in  1  memory_data carries a returned word
- memory_data  in  16  returned word
- fsm_busy  out  1  fill in progress; stalls the pipeline
- memory_read_en  out  1  a read request is issued this cycle
- memory_address  out  16  read request address, word-aligned
- write_data_array  out  1  write data_word into the data array this cycle
- data_word_sel  out  3  word offset within the block for the data write
- data_word  out  16  registered copy of memory_data
- write_tag_array  out  1  one-cycle metadata write strobe
- tag_out  out  7  {1'b1, latched tag}
- set_enable  out  64  one-hot set select from the latched index; 0 in IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE. Every output is 0 and all counters clear.
- A reset mid-fill aborts the fill with no tag write. Partially written data words are harmless because the valid bit is never set.
- States: IDLE, FILL, DONE.
- IDLE:
  - On miss_detected=1, latch tag=miss_address[15:10] and index=miss_address[9:4].
  - Clear issue_cnt (4b) and recv_cnt (4b), then go to FILL.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy=1 and set_enable=onehot(index).
  - While issue_cnt<8: memory_read_en=1, memory_address={tag,index,issue_cnt[2:0],1'b0}, and issue_cnt increments every cycle. Requests go out on 8 consecutive cycles, first on the cycle after the miss.
  - When issue_cnt==8: memory_read_en=0 and memory_address holds the last value.
  - Each cycle with memory_data_valid=1: write_data_array=1 and data_word_sel=recv_cnt[2:0] in the following cycle, with data_word equal to that registered word; recv_cnt increments.
  - Words return in issue order. memory_data_valid may also arrive while issuing continues.
  - When the 8th word's write cycle completes, go to DONE.
  - miss_detected and miss_address are ignored while not IDLE.
  - A 9th memory_data_valid cannot occur. If one does, it is ignored (recv_cnt saturates at 8).
- DONE (one cycle):
  - write_tag_array=1, tag_out={1,tag}, set_enable=onehot(index), fsm_busy=1.
  - The next state is IDLE. A miss_detected in DONE is not accepted; the hit logic re-detects the miss in IDLE.
- Latency with MEM_LAT=4 and miss at cycle 0:
  - Requests in cycles 1..8, data valid in cycles 5..12, data writes in cycles 6..13.
  - Tag write in cycle 14, fsm_busy falls in cycle 15.
  - Total busy time is 14 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to fsm_busy or write_tag_array.

Decomposition:
- Shared package cache_pkg:
  - TAG_W=6, INDEX_W=6, OFFSET_W=4, WORDS=8, NUM_SETS=64.
  - State encoding constants IDLE=2'd0, FILL=2'd1, DONE=2'd2.
  - The metadata format {valid, tag} width = TAG_W+1.
- Sub-module set_decoder_6to64: index -> one-hot 64-bit set_enable with an enable input. This decoder is shared with the hit path.

Test Plan:
- Reset: hold rst=0 with a miss asserted, then release -> all outputs 0 and state IDLE. miss_detected is accepted starting the next rising edge.
- Basic fill: miss_address=16'hA4C6, memory model with 4-cycle latency returning word = address.
  - Expect memory_address 16'hA4C0, A4C2 … A4CE on cycles 1..8.
  - Expect data_word_sel 0..7 with matching data_word on cycles 6..13.
  - Expect write_tag_array pulse on cycle 14 with tag_out=7'b1_101001 and set_enable=1<<12.
- Back-to-back and ignored misses:
  - Miss during FILL at address 16'h0010 -> ignored, and the latched tag/index stay unchanged.
  - Second miss presented in cycle 15 -> new fill starts, with the first request on cycle 16.
- Stalled memory: valid pulses with random gaps (latency 4..10) -> exactly 8 data writes in order 0..7, then one tag write only after the 8th word.
- Reset mid-fill: assert rst=0 after 3 returned words -> outputs go to 0 asynchronously, and write_tag_array is never asserted for that fill.
- Boundary index: miss_address=16'hFFFE -> set_enable bit 63 only, tag_out=7'h7F, and memory addresses FFF0..FFFE with no wrap into the next block.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 2-way set-associative cache: the address split,
// block geometry, the fill FSM state encoding and the metadata word format.
// Imported by the fill FSM and by the set decoder that the hit path also uses.
// -----------------------------------------------------------------------------
package cache_pkg;

   // Byte address split: tag[15:10], index[9:4], offset[3:0]
   localparam int TAG_W    = 6;
   localparam int INDEX_W  = 6;
   localparam int OFFSET_W = 4;

   // Block geometry: 8 x 16-bit words = 16 bytes
   localparam int WORDS    = 8;
   localparam int WORD_W   = 16;
   localparam int NUM_SETS = 64;

   // Nominal main-memory read latency. The FSM never counts it; it only
   // follows memory_data_valid.
   localparam int MEM_LAT  = 4;

   // Metadata word written to the tag array: {valid, tag}
   localparam int META_W   = TAG_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_e;

   // Word-aligned byte address of word 'word' inside the block {tag, index}
   function automatic logic [TAG_W+INDEX_W+OFFSET_W-1:0] word_addr(
      input logic [TAG_W-1:0]   tag,
      input logic [INDEX_W-1:0] index,
      input logic [2:0]         word
   );
      return {tag, index, word, 1'b0};
   endfunction

endpackage

// File: rtl/set_decoder_6to64.sv
// -----------------------------------------------------------------------------
// set_decoder_6to64
// Turns a 6-bit set index into a one-hot 64-bit set select. With en low the
// output is all zeros. Shared between the fill FSM and the hit path.
//
// Ports:
//   en          in   1   enable; 0 forces set_enable to zero
//   index       in   6   set index
//   set_enable  out  64  one-hot set select
// -----------------------------------------------------------------------------
module set_decoder_6to64
   import cache_pkg::*;
(
   input  logic                en,
   input  logic [INDEX_W-1:0]  index,
   output logic [NUM_SETS-1:0] set_enable
);

   always_comb begin
      set_enable = '0;
      if (en) begin
         set_enable[index] = 1'b1;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
// Miss handler for one cache (I or D). On an accepted miss it issues eight
// word reads for the missing 16-byte block on consecutive cycles, writes each
// returned word into the data array one cycle after it arrives, and after the
// eighth write pulses a single metadata write of {1, tag} into the selected set.
//
// Ports:
//   clk                in   1   clock, rising edge
//   rst                in   1   asynchronous reset, active-low
//   miss_detected      in   1   miss this cycle (only looked at in IDLE)
//   miss_address       in   16  byte address of the missing access
//   memory_data_valid  in   1   memory_data carries a returned word
//   memory_data        in   16  returned word
//   fsm_busy           out  1   fill in progress (pipeline stall)
//   memory_read_en     out  1   read request this cycle
//   memory_address     out  16  word-aligned read address
//   write_data_array   out  1   data array write strobe
//   data_word_sel      out  3   word offset of the data write
//   data_word          out  16  registered copy of memory_data
//   write_tag_array    out  1   one-cycle metadata write strobe
//   tag_out            out  7   {1'b1, latched tag}
//   set_enable         out  64  one-hot set select, zero in IDLE
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
   parameter int ADDR_W = 16,
   parameter int WORDS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data,
   output logic              fsm_busy,
   output logic              memory_read_en,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic [2:0]        data_word_sel,
   output logic [15:0]       data_word,
   output logic              write_tag_array,
   output logic [6:0]        tag_out,
   output logic [63:0]       set_enable
);

   import cache_pkg::*;

   // Counter value once all words of the block have been issued / received
   localparam logic [3:0] WORD_CNT = 4'(WORDS);
   localparam logic [2:0] LAST_SEL = 3'(WORDS - 1);

   fill_state_e        state_q,     state_d;
   logic [TAG_W-1:0]   tag_q,       tag_d;
   logic [INDEX_W-1:0] index_q,     index_d;
   logic [3:0]         issue_cnt_q, issue_cnt_d;
   logic [3:0]         recv_cnt_q,  recv_cnt_d;
   logic               wr_q,        wr_d;
   logic [2:0]         sel_q,       sel_d;
   logic [WORD_W-1:0]  word_q,      word_d;

   // Byte offset of the miss is irrelevant: the whole block is fetched.
   logic unused_offset;
   assign unused_offset = ^miss_address[OFFSET_W-1:0];

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d starts as its _q (and the write strobe as 0), so no
      // branch can leave a variable unassigned and infer a latch.
      state_d     = state_q;
      tag_d       = tag_q;
      index_d     = index_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      wr_d        = 1'b0;
      sel_d       = sel_q;
      word_d      = word_q;

      unique case (state_q)
         IDLE: begin
            if (miss_detected) begin
               tag_d       = miss_address[15:10];
               index_d     = miss_address[9:4];
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
               state_d     = FILL;
            end
         end

         FILL: begin
            if (issue_cnt_q != WORD_CNT) begin
               issue_cnt_d = issue_cnt_q + 4'd1;
            end
            // Words return in issue order, so the receive count is the word
            // offset. Saturating at WORD_CNT drops any stray extra valid.
            if (memory_data_valid && (recv_cnt_q != WORD_CNT)) begin
               wr_d       = 1'b1;
               sel_d      = recv_cnt_q[2:0];
               word_d     = memory_data;
               recv_cnt_d = recv_cnt_q + 4'd1;
            end
            // Leave once the last word's data-array write is on the outputs.
            if (wr_q && (sel_q == LAST_SEL)) begin
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      if (!rst) begin
         state_q     <= IDLE;
         tag_q       <= '0;
         index_q     <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         wr_q        <= 1'b0;
         sel_q       <= '0;
         word_q      <= '0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         index_q     <= index_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         wr_q        <= wr_d;
         sel_q       <= sel_d;
         word_q      <= word_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs, decoded only from registered state
   // ------------------------------------------------------------------------
   logic       in_fill;
   logic       issuing;
   logic [2:0] issue_word;

   assign in_fill = (state_q == FILL);
   assign issuing = in_fill && (issue_cnt_q != WORD_CNT);

   // After the last request the address holds on the final word of the block.
   assign issue_word = issuing ? issue_cnt_q[2:0] : LAST_SEL;

   assign fsm_busy         = (state_q != IDLE);
   assign memory_read_en   = issuing;
   assign memory_address   = in_fill ? word_addr(tag_q, index_q, issue_word) : '0;
   assign write_data_array = wr_q;
   assign data_word_sel    = sel_q;
   assign data_word        = word_q;
   assign write_tag_array  = (state_q == DONE);
   assign tag_out          = (state_q == DONE) ? {1'b1, tag_q} : '0;

   set_decoder_6to64 u_set_decoder (
      .en         (fsm_busy),
      .index      (index_q),
      .set_enable (set_enable)
   );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
// Drives cache_fill_fsm cycle by cycle from one initial block. A memory
// responder answers every observed read request after a chosen latency, and a
// reference model kept as queues of timed events (expected requests, expected
// data writes, expected tag-write cycle, busy window) is checked every cycle.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = '0;
   logic        memory_data_valid = 1'b0;
   logic [15:0] memory_data = '0;

   logic        fsm_busy;
   logic        memory_read_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  data_word_sel;
   logic [15:0] data_word;
   logic        write_tag_array;
   logic [6:0]  tag_out;
   logic [63:0] set_enable;

   always #5 clk = ~clk;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .memory_read_en    (memory_read_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .data_word_sel     (data_word_sel),
      .data_word         (data_word),
      .write_tag_array   (write_tag_array),
      .tag_out           (tag_out),
      .set_enable        (set_enable)
   );

   // ------------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------------
   typedef struct { int cyc; logic [15:0] addr; } req_t;
   typedef struct { int cyc; logic [2:0] sel; logic [15:0] word; } wr_t;
   typedef struct { int due; logic [15:0] data; } ret_t;

   req_t req_q[$];   // expected read requests
   wr_t  wr_q[$];    // expected data-array writes
   ret_t ret_q[$];   // memory returns still in flight

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          m_busy_from = -1;
   int          m_busy_to   = -1;
   int          m_tag_cyc   = -1;
   int          m_words     = 0;
   bit          m_fill      = 1'b0;
   logic [5:0]  m_tag       = '0;
   logic [5:0]  m_index     = '0;
   int          last_due    = -1;
   int          lat_min     = MEM_LAT;
   int          lat_max     = MEM_LAT;
   logic [15:0] salt        = '0;

   // Observations for cycle-exact literal checks
   int          miss_cyc    = 0;
   int          busy_cnt    = 0;
   int          obs_tag_cyc = -1;
   logic [6:0]  obs_tag     = '0;
   logic [63:0] obs_set     = '0;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h",
                tag, cyc, observed, expected);
      end
   endtask

   function automatic bit model_busy(input int c);
      return (m_busy_from >= 0) && (c >= m_busy_from) && (c <= m_busy_to);
   endfunction

   task automatic model_reset();
      req_q.delete();
      wr_q.delete();
      m_busy_from = -1;
      m_busy_to   = -1;
      m_tag_cyc   = -1;
      m_fill      = 1'b0;
      m_words     = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},    fsm_busy,         0);
      check({tag, "_rd_en"},   memory_read_en,   0);
      check({tag, "_rd_addr"}, memory_address,   0);
      check({tag, "_wr_data"}, write_data_array, 0);
      check({tag, "_sel"},     data_word_sel,    0);
      check({tag, "_word"},    data_word,        0);
      check({tag, "_wr_tag"},  write_tag_array,  0);
      check({tag, "_tag_out"}, tag_out,          0);
      check({tag, "_set_en"},  set_enable,       0);
   endtask

   // One clock cycle: sample and check at the falling edge, run the memory
   // responder, drive this cycle's inputs, then advance past the rising edge.
   task automatic step(input logic miss, input logic [15:0] addr);
      bit exp_en, exp_wr, exp_tag, exp_busy;
      int due;
      @(negedge clk);
      exp_busy = model_busy(cyc);
      exp_en   = (req_q.size() > 0) && (req_q[0].cyc == cyc);
      exp_wr   = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
      exp_tag  = (cyc == m_tag_cyc);

      check("read_en", memory_read_en, exp_en);
      if (exp_en) begin
         check("read_addr", memory_address, req_q[0].addr);
         void'(req_q.pop_front());
      end
      check("data_we", write_data_array, exp_wr);
      if (exp_wr) begin
         check("data_sel",  data_word_sel, wr_q[0].sel);
         check("data_word", data_word,     wr_q[0].word);
         void'(wr_q.pop_front());
      end
      check("tag_we", write_tag_array, exp_tag);
      if (exp_tag) check("tag_out", tag_out, {1'b1, m_tag});
      check("busy", fsm_busy, exp_busy);
      check("set_en", set_enable, exp_busy ? (64'd1 << m_index) : 64'd0);

      if (fsm_busy) busy_cnt++;
      if (write_tag_array) begin
         obs_tag_cyc = cyc;
         obs_tag     = tag_out;
         obs_set     = set_enable;
      end

      // Memory: answer each request in order after a latency in [min,max]
      if (memory_read_en) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         ret_q.push_back('{due, memory_address ^ salt});
         last_due = due;
      end
      if ((ret_q.size() > 0) && (ret_q[0].due == cyc)) begin
         memory_data_valid = 1'b1;
         memory_data       = ret_q[0].data;
         if (m_fill) begin
            wr_q.push_back('{cyc + 1, 3'(m_words), ret_q[0].data});
            m_words++;
            if (m_words == WORDS) begin
               m_fill    = 1'b0;
               m_tag_cyc = cyc + 2;
               m_busy_to = cyc + 2;
            end
         end
         void'(ret_q.pop_front());
      end else begin
         memory_data_valid = 1'b0;
         memory_data       = 16'($urandom);
      end

      miss_detected = miss;
      miss_address  = addr;
      if (rst && miss && !exp_busy) begin
         m_tag   = addr[15:10];
         m_index = addr[9:4];
         for (int i = 0; i < WORDS; i++)
            req_q.push_back('{cyc + 1 + i, (addr & 16'hFFF0) + 16'(2 * i)});
         m_busy_from = cyc + 1;
         m_busy_to   = 32'h7FFF_FFFF;
         m_fill      = 1'b1;
         m_words     = 0;
         m_tag_cyc   = -1;
         miss_cyc    = cyc;
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Steps until the next cycle to be sampled is the expected tag-write cycle.
   task automatic run_until_done(input bit noisy);
      int n = 0;
      while ((cyc != m_tag_cyc) && (n < 200)) begin
         step(noisy ? 1'($urandom) : 1'b0, 16'($urandom));
         n++;
      end
      check("fill_completes", cyc == m_tag_cyc, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      int n;

      // Reset held with a miss pending: outputs stay zero, miss not taken
      #1 rst = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) step(1'b1, 16'hA4C6);

      // Release with the miss still asserted: accepted on the next edge
      rst = 1'b1;
      busy_cnt = 0;
      step(1'b1, 16'hA4C6);
      step(1'b0, 16'h0000);
      step(1'b0, 16'h0000);
      step(1'b1, 16'h0010);              // ignored, fill keeps A4C6
      run_until_done(1'b0);
      step(1'b1, 16'h5A38);              // DONE cycle: miss not accepted
      check("basic_tag_cycle", obs_tag_cyc - miss_cyc, 14);
      check("basic_tag_out",   obs_tag, 7'b1_101001);
      check("basic_set_en",    obs_set, 64'd1 << 12);
      check("basic_busy_cnt",  busy_cnt, 14);

      // Back-to-back: miss in the cycle after DONE starts the next fill
      step(1'b1, 16'h5A38);
      run_until_done(1'b0);
      step(1'b0, 16'h0000);
      check("b2b_tag_out", obs_tag, {1'b1, 6'h16});

      // Stalled memory: random latency 4..10, random addresses and data
      lat_min = 4;
      lat_max = 10;
      for (int f = 0; f < 4; f++) begin
         salt = 16'($urandom);
         a    = 16'($urandom);
         step(1'b1, a);
         run_until_done(1'b1);
         step(1'b0, 16'h0000);
         check("stall_tag_out", obs_tag, {1'b1, a[15:10]});
         repeat (2) step(1'b0, 16'h0000);
      end

      // Reset mid-fill after three returned words
      lat_min = MEM_LAT;
      lat_max = MEM_LAT;
      salt    = 16'h0000;
      obs_tag_cyc = -1;
      step(1'b1, 16'h3C50);
      n = 0;
      while ((m_words < 3) && (n < 50)) begin
         step(1'b0, 16'h0000);
         n++;
      end
      check("three_words_seen", m_words, 3);
      step(1'b0, 16'h0000);
      #2 rst = 1'b0;
      #1 check_all_zero("async_reset");
      model_reset();
      repeat (3) step(1'b0, 16'h0000);
      rst = 1'b1;
      repeat (20) step(1'b0, 16'h0000);  // stale returns arrive while idle
      check("aborted_no_tag", obs_tag_cyc, -1);

      // Boundary: top set, all-ones tag, block FFF0..FFFE
      step(1'b1, 16'hFFFE);
      run_until_done(1'b0);
      step(1'b0, 16'h0000);
      check("edge_tag_out", obs_tag, 7'h7F);
      check("edge_set_en",  obs_set, 64'h8000_0000_0000_0000);
      repeat (3) step(1'b0, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
